if_stage_fetch: RTL and testbench
=================================

// Module: if_stage_fetch
// PURPOSE
//  Instruction-fetch front end: owns PC, issues instruction-memory requests, loads IF/ID register.
//  Consumes the hazard unit's pcwrite/fdwrite stall outputs; accepts branch/jump redirects from EX.
//  One outstanding request; variable-latency memory; 1-entry hold buffer absorbs a fetch that returns during a stall.
// PARAMETERS
//  XLEN      32            address/instruction width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  NOP_INSTR 32'h0000_0013 instruction written into IF/ID on flush (addi x0,x0,0)
// PORTS
//  clk         in   1     single clock, rising edge
//  rst         in   1     synchronous, active-high reset
//  pcwrite     in   1     from hazard_detection; 0 = stall PC
//  fdwrite     in   1     from hazard_detection; 0 = hold IF/ID
//  redirect    in   1     taken branch/jump; flush and refetch
//  redirect_pc in   XLEN  redirect target, valid with redirect
//  imem_req    out  1     request valid
//  imem_addr   out  XLEN  request address, stable while imem_req=1
//  imem_ack    in   1     1-cycle pulse, imem_rdata valid this cycle
//  imem_rdata  in   XLEN  fetched instruction
//  ifid_valid  out  1     IF/ID holds a real instruction
//  ifid_pc     out  XLEN  PC of IF/ID instruction
//  ifid_instr  out  XLEN  IF/ID instruction
//  fetch_wait  out  1     IF/ID starved this cycle (bubble due to memory)
// BEHAVIOUR
//  stall = ~pcwrite | ~fdwrite. Registers: state, req_addr, tgt, hold{pc,instr}, IF/ID.
//  Reset (any state, overrides all): state=IDLE, req_addr=RESET_PC, ifid_valid=0, ifid_pc=0,
//   ifid_instr=NOP_INSTR; imem_req=0 in the cycle after rst. Outstanding ack during reset is ignored.
//  imem_req=1 iff state in {REQ,DRAIN}; imem_addr=req_addr (held constant until ack).
//  States:
//   IDLE : -> REQ next cycle (redirect here: req_addr<=redirect_pc).
//   REQ  : no ack: wait. ack & ~redirect & ~stall: IF/ID<={1,req_addr,rdata}, req_addr+=4, stay REQ
//          (next request issued next cycle => 1 instr/2 cycles min; latency ack->IF/ID = 1 edge).
//          ack & ~redirect & stall: hold<={req_addr,rdata}, req_addr+=4, -> HOLD.
//   HOLD : imem_req=0. ~stall: IF/ID<={1,hold}, -> REQ. stall: wait.
//   DRAIN: request superseded by redirect; wait ack, discard rdata, req_addr<=tgt, -> REQ.
//  Redirect (priority over stall and ack, all states): IF/ID<={0,0,NOP_INSTR} at next edge;
//   REQ w/o ack -> DRAIN, tgt<=redirect_pc; REQ with ack same cycle -> rdata dropped,
//   req_addr<=redirect_pc, -> REQ; HOLD -> hold dropped, req_addr<=redirect_pc, -> REQ;
//   DRAIN -> tgt<=redirect_pc (latest wins), stay DRAIN.
//  IF/ID when fdwrite=0 and no redirect: all three fields held unchanged.
//  IF/ID when fdwrite=1, no redirect, nothing delivered: ifid_valid<=0, pc/instr unchanged; fetch_wait=1
//   (fetch_wait combinational: fdwrite & ~redirect & no delivery this cycle).
//  PC arithmetic: req_addr+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0). No alignment check.
//  ack outside REQ/DRAIN is ignored (protocol error, flagged by assertion in sim).
// TESTING
//  1 rst 2 cycles, ack 1 cycle after each req, rdata=0xA0+n -> imem_addr 0,4,8; ifid_pc 0,4,8, valid.
//  2 ack arrives with fdwrite=pcwrite=0 for 3 cycles -> HOLD, imem_req=0, IF/ID unchanged;
//    stall drops -> IF/ID gets held instr/pc next edge, request for next addr follows.
//  3 redirect_pc=0x100 while req for 0x8 pending, ack 2 cycles later -> that rdata discarded,
//    ifid_valid=0 with NOP_INSTR, next imem_addr=0x100.
//  4 redirect and ack same cycle -> rdata dropped, next imem_addr=redirect_pc, no DRAIN.
//  5 two redirects (0x200 then 0x300) during DRAIN -> fetch resumes at 0x300 only.
//  6 rst asserted mid-request with ack 1 cycle later -> ack ignored, first fetch at RESET_PC;
//    req_addr 0xFFFF_FFFC delivered -> next imem_addr 0x0.

Source files
------------

// File: rtl/if_stage_fetch.sv
// rtl/if_stage_fetch.sv - instruction-fetch front end: PC, imem requests, hold buffer, IF/ID register
module if_stage_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcwrite,
    input  logic            fdwrite,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr,
    output logic            fetch_wait
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] w_req_addr_nxt;
    logic [XLEN-1:0] r_tgt;
    logic [XLEN-1:0] w_tgt_nxt;
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] r_hold_instr;
    logic            w_hold_load;
    logic            w_deliver;
    logic [XLEN-1:0] w_dlv_pc;
    logic [XLEN-1:0] w_dlv_instr;
    logic            w_stall;
    logic [XLEN-1:0] w_addr_inc;

    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_instr;

    assign w_stall    = ~pcwrite | ~fdwrite;
    assign w_addr_inc = r_req_addr + XLEN'(4);

    always_comb begin
        w_state_nxt    = r_state;
        w_req_addr_nxt = r_req_addr;
        w_tgt_nxt      = r_tgt;
        w_hold_load    = 1'b0;
        w_deliver      = 1'b0;
        w_dlv_pc       = r_req_addr;
        w_dlv_instr    = imem_rdata;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect) w_req_addr_nxt = redirect_pc;
            end
            S_REQ: begin
                if (redirect) begin
                    // Without an ack the request is still in flight and must be drained first.
                    if (imem_ack) begin
                        w_req_addr_nxt = redirect_pc;
                    end else begin
                        w_tgt_nxt   = redirect_pc;
                        w_state_nxt = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    w_req_addr_nxt = w_addr_inc;
                    if (w_stall) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_deliver = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_req_addr_nxt = redirect_pc;
                    w_state_nxt    = S_REQ;
                end else if (!w_stall) begin
                    w_deliver   = 1'b1;
                    w_dlv_pc    = r_hold_pc;
                    w_dlv_instr = r_hold_instr;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                // A redirect coinciding with the draining ack wins over the saved target.
                if (imem_ack) begin
                    w_req_addr_nxt = redirect ? redirect_pc : r_tgt;
                    w_state_nxt    = S_REQ;
                end else if (redirect) begin
                    w_tgt_nxt = redirect_pc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_addr   <= RESET_PC;
            r_tgt        <= '0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_tgt      <= w_tgt_nxt;
            if (w_hold_load) begin
                r_hold_pc    <= r_req_addr;
                r_hold_instr <= imem_rdata;
            end
            if (redirect) begin
                r_ifid_valid <= 1'b0;
                r_ifid_pc    <= '0;
                r_ifid_instr <= NOP_INSTR;
            end else if (w_deliver) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= w_dlv_pc;
                r_ifid_instr <= w_dlv_instr;
            end else if (fdwrite) begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

    assign imem_req   = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr  = r_req_addr;
    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign fetch_wait = fdwrite & ~redirect & ~w_deliver;

    a_ack_in_flight: assert property (@(posedge clk) disable iff (rst)
        imem_ack |-> ((r_state == S_REQ) || (r_state == S_DRAIN)));

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb/tb_if_stage_fetch.sv - randomized bench for if_stage_fetch against a transaction-level model
module tb_if_stage_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcwrite = 1'b1;
    logic        fdwrite = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        fetch_wait;

    if_stage_fetch dut (
        .clk(clk), .rst(rst), .pcwrite(pcwrite), .fdwrite(fdwrite),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .fetch_wait(fetch_wait)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: is a request on the bus, is it superseded, pending fetch address, parked fetch.
    bit          m_busy = 0;
    bit          m_stale = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_tgt = '0;
    logic [63:0] m_hold[$];
    bit          mv = 0;
    logic [31:0] mpc = '0;
    logic [31:0] minstr = NOP;

    int p_rst = 0, p_stall = 0, p_redir = 0;
    int cnt = 0, lat = 1;
    bit force_redir = 0;
    logic [31:0] force_pc = '0;

    function automatic bit exp_deliver();
        bit stall;
        stall = !(pcwrite && fdwrite);
        if (redirect) return 0;
        if (!m_busy && m_hold.size() != 0) return !stall;
        if (m_busy && !m_stale && imem_ack) return !stall;
        return 0;
    endfunction

    task automatic model_step();
        bit stall;
        bit dl;
        logic [31:0] dpc, di;
        if (rst) begin
            m_busy = 0; m_stale = 0; m_addr = '0; m_tgt = '0;
            m_hold.delete();
            mv = 0; mpc = '0; minstr = NOP;
            return;
        end
        stall = !(pcwrite && fdwrite);
        dl = 0; dpc = '0; di = '0;
        if (redirect) begin
            if (m_busy && !imem_ack) begin
                m_stale = 1; m_tgt = redirect_pc;
            end else begin
                m_addr = redirect_pc; m_busy = 1; m_stale = 0; m_hold.delete();
            end
            mv = 0; mpc = '0; minstr = NOP;
        end else begin
            if (!m_busy) begin
                if (m_hold.size() == 0) m_busy = 1;
                else if (!stall) begin
                    dl = 1; {dpc, di} = m_hold.pop_front(); m_busy = 1;
                end
            end else if (m_stale) begin
                if (imem_ack) begin m_addr = m_tgt; m_stale = 0; end
            end else if (imem_ack) begin
                if (stall) begin m_hold.push_back({m_addr, imem_rdata}); m_busy = 0; end
                else begin dl = 1; dpc = m_addr; di = imem_rdata; end
                m_addr = m_addr + 32'd4;
            end
            if (dl) begin mv = 1; mpc = dpc; minstr = di; end
            else if (fdwrite) mv = 0;
        end
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(0, 5))
            0: return 32'h100;
            1: return 32'h200;
            2: return 32'h300;
            3: return 32'hFFFF_FFF8;
            4: return 32'hFFFF_FFFC;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic drive();
        rst         = ($urandom_range(0, 99) < p_rst);
        pcwrite     = !($urandom_range(0, 99) < p_stall);
        fdwrite     = !($urandom_range(0, 99) < p_stall);
        redirect    = ($urandom_range(0, 99) < p_redir);
        redirect_pc = pick_pc();
        if (force_redir) begin
            redirect = 1; redirect_pc = force_pc; force_redir = 0;
        end
        imem_ack = 0;
        if (m_busy) begin
            if (cnt >= lat) begin
                imem_ack = 1; cnt = 0; lat = $urandom_range(0, 3);
            end else cnt++;
        end
        imem_rdata = $urandom;
        if (rst) cnt = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_step();
            if (rst) begin
                chk("rst_req", {31'd0, imem_req}, 32'd0);
                chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
                chk("rst_instr", ifid_instr, NOP);
            end
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
            if (m_busy) chk("imem_addr", imem_addr, m_addr);
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, mv});
            chk("ifid_pc", ifid_pc, mpc);
            chk("ifid_instr", ifid_instr, minstr);
            drive();
            #1;
            if (!rst) chk("fetch_wait", {31'd0, fetch_wait},
                          {31'd0, fdwrite && !redirect && !exp_deliver()});
        end
    endtask

    initial begin
        p_rst = 100; run(2);
        p_rst = 0;   run(20);
        p_stall = 40; run(300);
        p_stall = 20; p_redir = 30; run(400);
        p_stall = 0;  p_redir = 15; run(200);
        p_stall = 30; p_redir = 20; p_rst = 4; run(500);
        p_stall = 0;  p_redir = 0;  p_rst = 0; run(4);
        force_redir = 1; force_pc = 32'hFFFF_FFF8; run(16);
        p_stall = 50; force_redir = 1; force_pc = 32'hFFFF_FFFC; run(30);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
